ram_test_sequencer: RTL
=======================

// Module: ram_test_sequencer
// PURPOSE
//  Top-level scheduler for the RAM stress test. Runs the full test without any other control logic.
//  - Pulses write_mem to load the alternating 0xAA/0x55 pattern, then waits a write window.
//  - Pulses align to switch the RAM controller into read/check mode, then masks the pipeline-settle window.
//  - During the read window, counts error_1/error_2 events and logs their addresses into a small readable FIFO.
//  - Supports single-pass or continuous operation.
// PARAMETERS
//  ADDR_W        10    width of error_address_1/2
//  PULSE_CYCLES  4     cycles write_mem / align are held high
//  WRITE_CYCLES  8192  write-window length after write_mem drops (>= 8 full address sweeps)
//  SETTLE_CYCLES 16    cycles after align drops during which errors are ignored
//  READ_CYCLES   65536 read/check window length per pass
//  LOG_DEPTH     8     error-log FIFO entries (power of 2)
//  CNT_W         16    err_count width
// PORTS
//  clk             in   1        single clock (same domain as error inputs)
//  reset           in   1        synchronous, active-high
//  start           in   1        pulse: begin test (ignored while busy)
//  stop            in   1        abort: return to IDLE next cycle
//  continuous      in   1        1 = loop ALIGN..READ until stop
//  error_1         in   1        even-side mismatch flag
//  error_2         in   1        odd-side mismatch flag
//  error_address_1 in   ADDR_W   address paired with error_1
//  error_address_2 in   ADDR_W   address paired with error_2
//  write_mem       out  1        to RAM controller: restart write phase
//  align           out  1        to RAM controller: enter read phase
//  busy            out  1        high in any state but IDLE
//  done            out  1        1-cycle pulse when a non-continuous run ends
//  pass_count      out  8        completed read passes, saturating at 255
//  err_count       out  CNT_W    error events (error_1 + error_2), saturating
//  log_rd          in   1        pop log head (ignored when empty)
//  log_valid       out  1        log non-empty
//  log_data        out  2+2*ADDR_W  {e1,e2,addr1,addr2} of log head
//  log_overflow    out  1        sticky: an entry was dropped on full
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; log emptied; counters cleared. Same effect if reset is asserted mid-run.
//  States and transitions:
//   - IDLE -> WPULSE when start=1. Clears err_count, pass_count, log and overflow.
//   - WPULSE (write_mem=1, PULSE_CYCLES cycles) -> WRITE.
//   - WRITE (WRITE_CYCLES) -> APULSE.
//   - APULSE (align=1, PULSE_CYCLES) -> SETTLE.
//   - SETTLE (SETTLE_CYCLES) -> READ.
//   - READ (READ_CYCLES) -> on exit, pass_count+1. If continuous=1 (sampled on the last READ cycle) -> APULSE;
//     otherwise -> IDLE with done=1 for 1 cycle.
//  Timing:
//   - All outputs are registered. write_mem rises the cycle after start is sampled.
//   - busy rises together with write_mem.
//  Error handling:
//   - Errors are sampled only in READ. They are ignored in every other state.
//   - err_count adds error_1+error_2 (0..2) per cycle and saturates at 2^CNT_W-1.
//   - Any cycle with error_1|error_2 pushes one log entry holding both flags and both addresses.
//  Log FIFO:
//   - Full + push without pop: entry dropped, log_overflow=1 until next start/reset.
//   - Full + push + pop in the same cycle: both occur, no overflow.
//   - Empty + log_rd: no effect.
//   - log_data is valid whenever log_valid=1, and the log stays readable in IDLE.
//  stop:
//   - From any non-IDLE state -> IDLE next cycle, with write_mem=align=0 and done not pulsed.
//   - Counters and log are retained.
//  Simultaneous start+stop in IDLE: start wins.
//  Simultaneous stop+reset: reset wins.
// STRUCTURE
//  ram_test_pkg: state encoding localparams and the log entry width function.
//  Sub-module error_log_fifo: sync FIFO, LOG_DEPTH x (2+2*ADDR_W), with push/pop/full/empty.
//  Phase counter: one down-counter sized for max(WRITE_CYCLES, READ_CYCLES), reloaded on every state change.
// TESTING (bench params: PULSE=4, WRITE=32, SETTLE=4, READ=64, LOG_DEPTH=4)
//  1. start at cycle 0, no errors -> write_mem high cycles 1-4, align high cycles 37-40,
//     done pulse at cycle 109, pass_count=1, err_count=0.
//  2. error_1=1 with addr 0x155 on read cycle 10 -> err_count=1; log_data={1,0,0x155,x}; log_rd empties the log.
//  3. error_1=error_2=1 on 6 read cycles, no pops -> err_count=12, 4 entries held, log_overflow=1.
//  4. error pulses during WRITE and SETTLE -> err_count=0, log empty.
//  5. continuous=1, stop asserted after 3 passes -> pass_count=3, busy=0 next cycle, done never pulsed,
//     align re-pulsed before each pass.
//  6. reset asserted mid-READ with a non-empty log -> all outputs 0 next cycle; a new start runs normally.

Source files
------------

// File: rtl/ram_test_pkg.sv
// RAM stress test sequencer: shared state encoding and log entry sizing.
// Imported by the sequencer top and its error-log FIFO.
package ram_test_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WPULSE,
    S_WRITE,
    S_APULSE,
    S_SETTLE,
    S_READ
  } state_t;

  function automatic int log_w(input int addr_w);
    return 2 + 2 * addr_w;
  endfunction

endpackage

// File: rtl/ram_test_sequencer_fifo.sv
// Error-log FIFO: synchronous, power-of-two depth, sticky overflow flag.
// Head entry is presented combinationally; reads as zero when empty.
module error_log_fifo #(
  parameter int W     = 22,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic         overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) &&
                   (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop && !empty;
  // a pop frees the slot, so a push into a full log still lands
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push && !reset && !clear) begin
      mem[wp[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wp       <= '0;
      rp       <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      if (push && full && !do_pop) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/ram_test_sequencer.sv
// RAM stress test scheduler: write phase, align, settle, then a read
// window that counts and logs error events; single-pass or looping.
module ram_test_sequencer
  import ram_test_pkg::*;
#(
  parameter int ADDR_W        = 10,
  parameter int PULSE_CYCLES  = 4,
  parameter int WRITE_CYCLES  = 8192,
  parameter int SETTLE_CYCLES = 16,
  parameter int READ_CYCLES   = 65536,
  parameter int LOG_DEPTH     = 8,
  parameter int CNT_W         = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       continuous,
  input  logic                       error_1,
  input  logic                       error_2,
  input  logic [ADDR_W-1:0]          error_address_1,
  input  logic [ADDR_W-1:0]          error_address_2,
  output logic                       write_mem,
  output logic                       align,
  output logic                       busy,
  output logic                       done,
  output logic [7:0]                 pass_count,
  output logic [CNT_W-1:0]           err_count,
  input  logic                       log_rd,
  output logic                       log_valid,
  output logic [log_w(ADDR_W)-1:0]   log_data,
  output logic                       log_overflow
);

  localparam int LW   = log_w(ADDR_W);
  localparam int M1   = (WRITE_CYCLES > READ_CYCLES) ?
                        WRITE_CYCLES : READ_CYCLES;
  localparam int M2   = (PULSE_CYCLES > SETTLE_CYCLES) ?
                        PULSE_CYCLES : SETTLE_CYCLES;
  localparam int MAXC = (M1 > M2) ? M1 : M2;
  localparam int PW   = $clog2(MAXC + 1);

  state_t           state;
  state_t           nxt;
  logic [PW-1:0]    phase;
  logic [PW-1:0]    reload;
  logic             last;
  logic [CNT_W:0]   err_sum;
  logic             log_clear;
  logic             log_push;
  logic             log_full;
  logic             log_empty;

  assign last      = (phase == '0);
  assign log_clear = (state == S_IDLE) && start;
  assign log_push  = (state == S_READ) && (error_1 || error_2);
  assign log_valid = !log_empty;
  assign err_sum   = {1'b0, err_count} +
                     (CNT_W+1)'(error_1) +
                     (CNT_W+1)'(error_2);

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (start) nxt = S_WPULSE;
      S_WPULSE: if (last)  nxt = S_WRITE;
      S_WRITE:  if (last)  nxt = S_APULSE;
      S_APULSE: if (last)  nxt = S_SETTLE;
      S_SETTLE: if (last)  nxt = S_READ;
      S_READ:   if (last)  nxt = continuous ? S_APULSE : S_IDLE;
      default:             nxt = S_IDLE;
    endcase
    if (stop && state != S_IDLE) nxt = S_IDLE;
  end

  always_comb begin
    reload = '0;
    unique case (nxt)
      S_WPULSE: reload = PW'(PULSE_CYCLES - 1);
      S_APULSE: reload = PW'(PULSE_CYCLES - 1);
      S_WRITE:  reload = PW'(WRITE_CYCLES - 1);
      S_SETTLE: reload = PW'(SETTLE_CYCLES - 1);
      S_READ:   reload = PW'(READ_CYCLES - 1);
      default:  reload = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      phase      <= '0;
      write_mem  <= 1'b0;
      align      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass_count <= '0;
      err_count  <= '0;
    end else begin
      state     <= nxt;
      write_mem <= (nxt == S_WPULSE);
      align     <= (nxt == S_APULSE);
      busy      <= (nxt != S_IDLE);
      done      <= (state == S_READ) && last &&
                   !continuous && !stop;
      if (nxt != state) begin
        phase <= reload;
      end else if (phase != '0) begin
        phase <= phase - 1'b1;
      end
      if (log_clear) begin
        pass_count <= '0;
        err_count  <= '0;
      end else if (state == S_READ) begin
        err_count <= err_sum[CNT_W] ? '1 : err_sum[CNT_W-1:0];
        if (last && !stop && pass_count != 8'hFF) begin
          pass_count <= pass_count + 8'd1;
        end
      end
    end
  end

  error_log_fifo #(
    .W     (LW),
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk      (clk),
    .reset    (reset),
    .clear    (log_clear),
    .push     (log_push),
    .pop      (log_rd),
    .wdata    ({error_1, error_2, error_address_1, error_address_2}),
    .rdata    (log_data),
    .full     (log_full),
    .empty    (log_empty),
    .overflow (log_overflow)
  );

endmodule
